// File: rtl/ready_io_ctrl.sv
// ready_io_ctrl: front-end I/O for the picoRISC core.
// Synchronizes and debounces the pushbutton into a clean 'ready' level, and
// latches ALU results into the LED display register on the decoder's disp strobe.
module ready_io_ctrl #(
    parameter int DBNC_CYCLES = 4,
    parameter int CW          = $clog2(DBNC_CYCLES + 1),
    parameter int DW          = 8
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          btn_raw,
    input  logic          disp,
    input  logic [DW-1:0] disp_data,
    output logic          ready,
    output logic [DW-1:0] led,
    output logic          disp_valid
);

    // Bit 1 of the encoding is the debounced level, so 'ready' comes straight
    // from one flop and cannot glitch during state transitions.
    localparam logic [1:0] IDLE       = 2'b00;
    localparam logic [1:0] PRESS_WAIT = 2'b01;
    localparam logic [1:0] HELD       = 2'b10;
    localparam logic [1:0] REL_WAIT   = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(DBNC_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          s1_q, s2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] led_q;
    logic          disp_valid_q;

    // Two-flop synchronizer; btn_raw is asynchronous and only s2_q is used downstream.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Debounce next-state: a level change needs DBNC_CYCLES consecutive samples;
    // any opposite sample falls back to the stable state with the count cleared.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    if (DBNC_CYCLES == 1) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    if (DBNC_CYCLES == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = REL_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            REL_WAIT: begin
                if (s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Debounce state and counter registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Display register: latch on every disp strobe, pulse disp_valid the cycle after.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            led_q        <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            disp_valid_q <= disp;
            if (disp) begin
                led_q <= disp_data;
            end
        end
    end

    assign ready      = state_q[1];
    assign led        = led_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_ready_io_ctrl.sv
// Directed bench for ready_io_ctrl with DBNC_CYCLES=4, DW=8.
module tb_ready_io_ctrl;

    logic       Clock;
    logic       nReset;
    logic       btn_raw;
    logic       disp;
    logic [7:0] disp_data;
    logic       ready;
    logic [7:0] led;
    logic       disp_valid;

    int checks = 0;
    int errors = 0;

    // Decoder model: BREL on ready==1 lets the PC advance once per accepted press.
    logic       ready_prev;
    int         pc;

    ready_io_ctrl #(.DBNC_CYCLES(4), .DW(8)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .btn_raw    (btn_raw),
        .disp       (disp),
        .disp_data  (disp_data),
        .ready      (ready),
        .led        (led),
        .disp_valid (disp_valid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ready_prev <= 1'b0;
        end else begin
            ready_prev <= ready;
            if (ready && !ready_prev) pc <= pc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sit 1 time unit past it for sampling/driving.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int pc0;
        pc        = 0;
        nReset    = 1'b0;
        btn_raw   = 1'b0;
        disp      = 1'b0;
        disp_data = 8'h00;
        #1;
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_led", {24'b0, led}, 32'd0);
        chk("reset_dv", {31'b0, disp_valid}, 32'd0);
        step();
        step();
        nReset = 1'b1;
        step();
        step();
        chk("idle_ready", {31'b0, ready}, 32'd0);

        // Display: two back-to-back strobes, then idle.
        disp = 1'b1; disp_data = 8'h3C;
        step();
        chk("disp_led0", {24'b0, led}, 32'h3C);
        chk("disp_dv0", {31'b0, disp_valid}, 32'd1);
        disp_data = 8'h81;
        step();
        chk("disp_led1", {24'b0, led}, 32'h81);
        chk("disp_dv1", {31'b0, disp_valid}, 32'd1);
        disp = 1'b0; disp_data = 8'hFF;
        step();
        chk("disp_led_hold", {24'b0, led}, 32'h81);
        chk("disp_dv_off", {31'b0, disp_valid}, 32'd0);

        // Clean press: ready low for 5 edges after the change, high on the 6th.
        btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("press_wait", {31'b0, ready}, 32'd0);
        end
        step();
        chk("press_rise", {31'b0, ready}, 32'd1);

        // Release glitch: 2 cycles low are absorbed, ready stays high.
        btn_raw = 1'b0;
        step();
        step();
        btn_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("glitch_hold", {31'b0, ready}, 32'd1);
        end

        // Async reset with ready=1 and led=A5: all outputs drop before the next edge.
        disp = 1'b1; disp_data = 8'hA5;
        step();
        disp = 1'b0;
        chk("pre_rst_led", {24'b0, led}, 32'hA5);
        chk("pre_rst_ready", {31'b0, ready}, 32'd1);
        #2 nReset = 1'b0;
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_led", {24'b0, led}, 32'd0);
        chk("rst_dv", {31'b0, disp_valid}, 32'd0);
        #1 nReset = 1'b1;
        // Button still held: full sync + debounce latency again.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_repress_wait", {31'b0, ready}, 32'd0);
        end
        step();
        chk("rst_repress_rise", {31'b0, ready}, 32'd1);

        // Clean release.
        btn_raw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("release_wait", {31'b0, ready}, 32'd1);
        end
        step();
        chk("release_fall", {31'b0, ready}, 32'd0);
        step();
        step();

        // Bounce 1,1,0,1,1,1,1 then held: ready rises only after edge 8.
        pc0 = pc;
        begin
            logic [6:0] pat;
            pat = 7'b1111011; // bit i = sample before edge i
            for (int i = 0; i < 9; i++) begin
                btn_raw = (i < 7) ? pat[i] : 1'b1;
                step();
                chk("bounce", {31'b0, ready}, (i == 8) ? 32'd1 : 32'd0);
            end
        end
        step();
        chk("pc_after_press1", pc, pc0 + 1);

        // Decoder loop: PC stalls while released, advances exactly once on the next press.
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("pc_stall", pc, pc0 + 1);
        chk("released", {31'b0, ready}, 32'd0);
        btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("pc_after_press2", pc, pc0 + 2);
        chk("held2", {31'b0, ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
